// File: rtl/serial_word_feeder_if.sv
// Load/ready word handshake between an upstream word source and the serial feeder.
// The master offers Data with Load; the slave answers with Ready when it can take a word.
interface serial_word_feeder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] Data;
  logic             Load;
  logic             Ready;

  modport master (output Data, output Load, input Ready);
  modport slave  (input Data, input Load, output Ready);
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder: LSB-first, one bit per clock, with a one-word hold buffer
// so a word offered before the last-bit edge streams out with no idle gap.
module serial_word_feeder #(
  parameter int   WIDTH    = 16,
  parameter logic IDLE_BIT = 1'b0,
  parameter int   CNT_W    = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  serial_word_feeder_if.slave  up,
  output logic                 Out,
  output logic                 OutValid,
  output logic                 WordDone,
  output logic                 Busy,
  output logic [CNT_W-1:0]     WordCount
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic accept;
  logic last_bit;

  // Ready depends only on hold_full_q, so accept never loops back into an output.
  assign accept   = up.Load && !hold_full_q;
  assign last_bit = (state_q == SHIFT) && (idx_q == LAST_IDX);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = up.Data;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_q >> 1;
        idx_d  = idx_q + 1'b1;
        if (last_bit) begin
          cnt_d = cnt_q + 1'b1;
          idx_d = '0;
          // A held word has priority; a fresh Load can only land here when hold is empty.
          if (hold_full_q) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sreg_d = up.Data;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          hold_d      = up.Data;
          hold_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic shifting;
    shifting  = (state_q == SHIFT);
    up.Ready  = !hold_full_q;
    OutValid  = shifting;
    Out       = shifting ? sreg_q[0] : IDLE_BIT;
    WordDone  = shifting && (idx_q == LAST_IDX);
    Busy      = shifting || hold_full_q;
    WordCount = cnt_q;
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboarded bench: stimulus pushes expected serial bits, a forked monitor pops and compares.
module tb_serial_word_feeder;

  localparam int WIDTH = 16;

  logic Clk;
  logic Rst;

  serial_word_feeder_if #(.WIDTH(WIDTH)) up_if ();
  serial_word_feeder_if #(.WIDTH(WIDTH)) wrap_if ();

  logic       Out, OutValid, WordDone, Busy;
  logic [7:0] WordCount;
  logic       w_out, w_valid, w_done, w_busy;
  logic [1:0] w_count;

  serial_word_feeder #(.WIDTH(WIDTH), .IDLE_BIT(1'b0), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .up(up_if.slave),
    .Out(Out), .OutValid(OutValid), .WordDone(WordDone), .Busy(Busy), .WordCount(WordCount)
  );

  serial_word_feeder #(.WIDTH(WIDTH), .IDLE_BIT(1'b0), .CNT_W(2)) u_wrap (
    .Clk(Clk), .Rst(Rst), .up(wrap_if.slave),
    .Out(w_out), .OutValid(w_valid), .WordDone(w_done), .Busy(w_busy), .WordCount(w_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic b;
    logic wd;
  } exp_t;

  exp_t q[$];
  int   vecs;
  int   errs;
  int   cur_run;
  int   last_run;
  int   wrap_exp[5] = '{1, 2, 3, 0, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) q.push_back('{w[i], (i == WIDTH - 1)});
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge Clk);
      if (OutValid === 1'b1) begin
        cur_run++;
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_bit: got Out=%0b with no word pending at %0t", Out, $time);
        end else begin
          e = q.pop_front();
          chk("out_bit", 32'(Out), 32'(e.b));
          chk("word_done", 32'(WordDone), 32'(e.wd));
        end
      end else begin
        if (cur_run != 0) last_run = cur_run;
        cur_run = 0;
        chk("idle_out", 32'(Out), 32'd0);
        chk("idle_word_done", 32'(WordDone), 32'd0);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge Clk);
      n++;
    end
    if (q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL drain_timeout: got %0d bits still pending, expected 0", q.size());
      q.delete();
    end
    @(negedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    q.delete();
    cur_run  = 0;
    last_run = 0;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    cur_run = 0;
    last_run = 0;
    Rst = 1'b1;
    up_if.Load = 1'b1;
    up_if.Data = 16'hFFFF;
    wrap_if.Load = 1'b0;
    wrap_if.Data = '0;
    fork
      monitor_loop();
    join_none

    // Reset held two edges with Load asserted: nothing may be accepted.
    repeat (2) begin
      @(negedge Clk);
      #1;
      chk("rst_out", 32'(Out), 32'd0);
      chk("rst_valid", 32'(OutValid), 32'd0);
      chk("rst_ready", 32'(up_if.Ready), 32'd1);
      chk("rst_count", 32'(WordCount), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
    end
    Rst = 1'b0;
    up_if.Load = 1'b0;
    @(negedge Clk);
    #1;
    chk("post_rst_valid", 32'(OutValid), 32'd0);
    chk("post_rst_count", 32'(WordCount), 32'd0);

    // Single word from idle.
    @(posedge Clk);
    #1 up_if.Load = 1'b1;
    up_if.Data = 16'h1090;
    push_word(16'h1090);
    @(posedge Clk);
    #1 up_if.Load = 1'b0;
    wait_drain(40);
    chk("single_count", 32'(WordCount), 32'd1);
    chk("single_valid", 32'(OutValid), 32'd0);
    chk("single_out", 32'(Out), 32'd0);
    chk("single_busy", 32'(Busy), 32'd0);
    chk("single_run", 32'(last_run), 32'd16);

    // Back-to-back: second word parks in hold, then streams with no gap.
    do_reset();
    up_if.Load = 1'b1;
    up_if.Data = 16'h1090;
    push_word(16'h1090);
    @(posedge Clk);
    #1 up_if.Data = 16'hFFFF;
    push_word(16'hFFFF);
    @(posedge Clk);
    #1 up_if.Load = 1'b0;
    @(negedge Clk);
    #1;
    chk("b2b_ready_low", 32'(up_if.Ready), 32'd0);
    chk("b2b_busy", 32'(Busy), 32'd1);
    wait_drain(60);
    chk("b2b_run", 32'(last_run), 32'd32);
    chk("b2b_count", 32'(WordCount), 32'd2);
    chk("b2b_ready_high", 32'(up_if.Ready), 32'd1);
    chk("b2b_valid", 32'(OutValid), 32'd0);

    // Backpressure: third consecutive Load sees Ready low and is dropped.
    do_reset();
    up_if.Load = 1'b1;
    up_if.Data = 16'h0001;
    push_word(16'h0001);
    @(posedge Clk);
    #1 up_if.Data = 16'h0002;
    push_word(16'h0002);
    @(posedge Clk);
    #1 up_if.Data = 16'h0003;
    @(negedge Clk);
    #1;
    chk("bp_ready_low", 32'(up_if.Ready), 32'd0);
    @(posedge Clk);
    #1 up_if.Load = 1'b0;
    wait_drain(60);
    chk("bp_count", 32'(WordCount), 32'd2);
    chk("bp_run", 32'(last_run), 32'd32);
    chk("bp_valid", 32'(OutValid), 32'd0);

    // Reset mid-word, then a fresh word restarts at bit 0.
    do_reset();
    up_if.Load = 1'b1;
    up_if.Data = 16'h1090;
    push_word(16'h1090);
    @(posedge Clk);
    #1 up_if.Load = 1'b0;
    for (int n = 0; n < 30 && q.size() > 10; n++) @(posedge Clk);
    chk("mid_bits_seen", 32'(q.size()), 32'd10);
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    q.delete();
    @(negedge Clk);
    #1;
    chk("mid_rst_valid", 32'(OutValid), 32'd0);
    chk("mid_rst_ready", 32'(up_if.Ready), 32'd1);
    chk("mid_rst_count", 32'(WordCount), 32'd0);
    cur_run  = 0;
    last_run = 0;
    @(posedge Clk);
    #1 up_if.Load = 1'b1;
    up_if.Data = 16'hA5C3;
    push_word(16'hA5C3);
    @(posedge Clk);
    #1 up_if.Load = 1'b0;
    wait_drain(40);
    chk("mid_fresh_count", 32'(WordCount), 32'd1);
    chk("mid_fresh_run", 32'(last_run), 32'd16);

    // Counter wrap on the CNT_W=2 instance.
    do_reset();
    for (int w = 0; w < 5; w++) begin
      @(posedge Clk);
      #1 wrap_if.Load = 1'b1;
      wrap_if.Data = 16'(w + 1);
      @(posedge Clk);
      #1 wrap_if.Load = 1'b0;
      repeat (WIDTH) @(posedge Clk);
      @(negedge Clk);
      #1;
      chk("wrap_count", 32'(w_count), 32'(wrap_exp[w]));
      chk("wrap_valid", 32'(w_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/serial_word_feeder.md
# serial_word_feeder

Parallel-to-serial stage that sits directly upstream of the serial sequence detector. It accepts WIDTH-bit words over a load/ready handshake and presents them LSB-first on a 1-bit output, one bit per clock. A one-word holding buffer lets back-to-back words stream with no idle gap. It also flags word boundaries and counts the words it has sent.

## Interface
- WIDTH, 16, bits per word (≥2)
- IDLE_BIT, 1'b0, value driven on Out when no word is shifting
- CNT_W, 8, width of WordCount
- Clk  in  1  clock; all state changes on rising edge
- Rst  in  1  synchronous, active-high reset
- Data  in  WIDTH  word to serialize; sampled when Load && Ready
- Load  in  1  upstream offers Data this cycle
- Ready  out  1  holding buffer empty; word is accepted when Load && Ready at a rising edge
- Out  out  1  serial bit, feeds the detector's In
- OutValid  out  1  Out carries a word bit this cycle
- WordDone  out  1  high while the last bit (bit WIDTH-1) of a word is on Out
- Busy  out  1  shifter or holding buffer occupied
- WordCount  out  CNT_W  words fully shifted since reset; wraps modulo 2^CNT_W

## Operation
- Storage:
  - shift register sreg[WIDTH-1:0]
  - bit index idx, 0..WIDTH-1
  - holding register hold with flag hold_full
- States:
  - IDLE: shifter empty.
  - SHIFT: shifter holds a word.
- Accept (Load && Ready at an edge):
  - In IDLE, or in SHIFT on the last-bit cycle (idx==WIDTH-1) with hold empty: Data loads straight into sreg, idx=0, state→SHIFT.
  - Otherwise: Data goes to hold, hold_full=1.
- In SHIFT, each edge: sreg shifts right by 1 and idx increments.
- At an edge where idx==WIDTH-1:
  - WordCount increments.
  - If hold_full: hold moves to sreg, idx=0, hold_full=0, state stays SHIFT.
  - Else if a word is accepted at the same edge: it loads into sreg (stays SHIFT).
  - Else: state→IDLE.
- Outputs:
  - Ready = !hold_full.
  - Out = OutValid ? sreg[0] : IDLE_BIT.
  - OutValid = (state==SHIFT).
  - WordDone = OutValid && idx==WIDTH-1.
  - Busy = OutValid || hold_full.
- Load while !Ready: ignored; Data is not captured and no state changes.
- Rst high at an edge:
  - state=IDLE, hold_full=0, idx=0, WordCount=0.
  - Any word in flight or held is discarded.
  - Load is ignored at that edge.
- Reset values: Ready=1, Out=IDLE_BIT, OutValid=0, WordDone=0, Busy=0, WordCount=0.

## Timing
- Latency: word accepted at edge k from IDLE → bit0 on Out during cycle after edge k; bit i during cycle after edge k+i.
- One word occupies exactly WIDTH consecutive OutValid cycles.
- Throughput: one word per WIDTH cycles, with zero gap between words when hold is filled before the last-bit edge.
- Ready falls the cycle after hold fills. It rises the cycle after hold drains into sreg.
- Holding Load high continuously streams words gaplessly.
- WordCount updates at the edge ending the last bit, i.e. one cycle after WordDone is first seen.
- All outputs are registered or derived only from registers; there is no combinational path from Data/Load to any output.

## Test plan
- Reset: hold Rst for 2 edges while Load=1 with Data=16'hFFFF → Out=0, OutValid=0, Ready=1, WordCount=0 throughout; nothing is accepted.
- Single word: Load Data=16'h1090 for one cycle from IDLE → Out over the next 16 cycles = 0,0,0,0,1,0,0,1,0,0,0,0,1,0,0,0. WordDone is high only on the 16th bit. WordCount=1 afterwards, then OutValid=0 and Out=IDLE_BIT.
- Back-to-back: Load held high with 16'h1090 then 16'hFFFF → 32 contiguous OutValid cycles. The second word's bits are all 1. Ready is low while hold is full. WordCount=2.
- Backpressure: Load three words (16'h0001, 16'h0002, 16'h0003) on consecutive cycles → the third Load is seen with Ready=0 and is not accepted. Only 0001 then 0002 appear on Out, and WordCount=2.
- Reset mid-word: assert Rst after bit 5 of 16'h1090 → the next cycle shows OutValid=0, Ready=1 and WordCount unchanged at 0. A fresh word loaded after Rst deasserts starts again at bit0.
- Wrap: CNT_W=2, send 5 words → WordCount sequence 1,2,3,0,1.
